// File: rtl/ahb_slave_if.sv
// AHB-Lite slave front end of the AHB-to-APB bridge: address qualification, slot
// decode, one/two-phase pipeline copies and a two-cycle ERROR responder.
module ahb_slave_if #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned SLOT_BITS = 26,
    parameter int unsigned ERRCNT_W  = 8
) (
    input  logic                hclk,
    input  logic                hreset,
    input  logic                hready_in,
    input  logic [1:0]          htrans,
    input  logic [2:0]          hsize,
    input  logic                hwrite,
    input  logic [31:0]         haddr,
    input  logic [31:0]         hwdata,
    input  logic [31:0]         prdata,
    input  logic                hr_readyout,
    output logic                valid,
    output logic [2:0]          temp_sel,
    output logic [31:0]         haddr1,
    output logic [31:0]         haddr2,
    output logic [31:0]         hwdata1,
    output logic [31:0]         hwdata2,
    output logic                hwrite_reg,
    output logic                hwrite_reg1,
    output logic [31:0]         hrdata,
    output logic                hreadyout,
    output logic [1:0]          hresp,
    output logic [ERRCNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        E_IDLE = 2'd0,
        E_ERR1 = 2'd1,
        E_ERR2 = 2'd2
    } err_state_e;

    err_state_e            state_q, state_d;
    logic [ERRCNT_W-1:0]   err_count_q, err_count_d;
    logic [31:0]           haddr1_q, haddr2_q, hwdata1_q, hwdata2_q;
    logic                  hwrite1_q, hwrite2_q;

    logic [31:0] off;
    logic [31:0] slot;
    logic        mapped, size_ok, act, bad;

    assign off     = haddr - BASE_ADDR;
    assign slot    = off >> SLOT_BITS;
    assign mapped  = (haddr >= BASE_ADDR) && (slot < 32'd3);
    assign size_ok = (hsize <= 3'b010);
    assign act     = hready_in & htrans[1];
    assign bad     = act & (~mapped | ~size_ok);
    assign valid   = act & mapped & size_ok & (state_q == E_IDLE);

    always_comb begin
        temp_sel = 3'b000;
        if (mapped) begin
            case (slot[1:0])
                2'd0:    temp_sel = 3'b001;
                2'd1:    temp_sel = 3'b010;
                2'd2:    temp_sel = 3'b100;
                default: temp_sel = 3'b000;
            endcase
        end
    end

    // IDLE phases shift too; only a stalled bus holds the pipeline.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            haddr1_q  <= '0;
            haddr2_q  <= '0;
            hwdata1_q <= '0;
            hwdata2_q <= '0;
            hwrite1_q <= 1'b0;
            hwrite2_q <= 1'b0;
        end else if (hready_in) begin
            haddr1_q  <= haddr;
            haddr2_q  <= haddr1_q;
            hwdata1_q <= hwdata;
            hwdata2_q <= hwdata1_q;
            hwrite1_q <= hwrite;
            hwrite2_q <= hwrite1_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        err_count_d = err_count_q;
        case (state_q)
            E_IDLE: begin
                if (bad && hr_readyout) begin
                    state_d = E_ERR1;
                    if (err_count_q != {ERRCNT_W{1'b1}})
                        err_count_d = err_count_q + {{(ERRCNT_W-1){1'b0}}, 1'b1};
                end
            end
            E_ERR1:  state_d = E_ERR2;
            E_ERR2:  state_d = E_IDLE;
            default: state_d = E_IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= E_IDLE;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            err_count_q <= err_count_d;
        end
    end

    // ERROR is two cycles: first holds the master (ready low), second releases it.
    assign hreadyout   = (state_q == E_IDLE) ? hr_readyout : (state_q == E_ERR2);
    assign hresp       = (state_q == E_IDLE) ? 2'b00 : 2'b01;
    assign err_count   = err_count_q;
    assign hrdata      = prdata;
    assign haddr1      = haddr1_q;
    assign haddr2      = haddr2_q;
    assign hwdata1     = hwdata1_q;
    assign hwdata2     = hwdata2_q;
    assign hwrite_reg  = hwrite1_q;
    assign hwrite_reg1 = hwrite2_q;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Scoreboard bench for ahb_slave_if: stimulus queues expected values tagged with a
// cycle number, a negedge monitor pops and compares them against the DUT.
module tb_ahb_slave_if;

    localparam int S_VALID = 0, S_SEL = 1, S_HADDR1 = 2, S_HADDR2 = 3, S_HWDATA1 = 4,
                   S_HWDATA2 = 5, S_HWR = 6, S_HWR1 = 7, S_HRDY = 8, S_HRESP = 9,
                   S_ERRCNT = 10, S_HRDATA = 11;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic        hclk = 1'b0;
    logic        hreset, hready_in, hwrite, hr_readyout;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] haddr, hwdata, prdata;
    logic        valid, hwrite_reg, hwrite_reg1, hreadyout;
    logic [2:0]  temp_sel;
    logic [31:0] haddr1, haddr2, hwdata1, hwdata2, hrdata;
    logic [1:0]  hresp;
    logic [7:0]  err_count;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    ahb_slave_if dut (
        .hclk(hclk), .hreset(hreset), .hready_in(hready_in), .htrans(htrans),
        .hsize(hsize), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
        .prdata(prdata), .hr_readyout(hr_readyout), .valid(valid),
        .temp_sel(temp_sel), .haddr1(haddr1), .haddr2(haddr2), .hwdata1(hwdata1),
        .hwdata2(hwdata2), .hwrite_reg(hwrite_reg), .hwrite_reg1(hwrite_reg1),
        .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp), .err_count(err_count)
    );

    always #5 hclk = ~hclk;
    always @(posedge hclk) cyc <= cyc + 1;

    function automatic logic [31:0] pick(int s);
        case (s)
            S_VALID:   return {31'd0, valid};
            S_SEL:     return {29'd0, temp_sel};
            S_HADDR1:  return haddr1;
            S_HADDR2:  return haddr2;
            S_HWDATA1: return hwdata1;
            S_HWDATA2: return hwdata2;
            S_HWR:     return {31'd0, hwrite_reg};
            S_HWR1:    return {31'd0, hwrite_reg1};
            S_HRDY:    return {31'd0, hreadyout};
            S_HRESP:   return {30'd0, hresp};
            S_ERRCNT:  return {24'd0, err_count};
            default:   return hrdata;
        endcase
    endfunction

    always @(negedge hclk) begin
        exp_t it;
        logic [31:0] act;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            it  = q.pop_front();
            act = pick(it.sig);
            n_checks++;
            if (act !== it.exp) begin
                n_fail++;
                $display("FAIL %s (cycle %0d): got 0x%08h expected 0x%08h",
                         it.name, cyc, act, it.exp);
            end
        end
    end

    task automatic expect_sig(int sig, logic [31:0] v, string name);
        exp_t it;
        it.cyc  = cyc;
        it.sig  = sig;
        it.exp  = v;
        it.name = name;
        q.push_back(it);
    endtask

    task automatic step(int n = 1);
        repeat (n) @(posedge hclk);
        #1;
    endtask

    task automatic drive(logic [1:0] tr, logic [2:0] sz, logic wr, logic [31:0] a,
                         logic [31:0] d);
        htrans = tr;
        hsize  = sz;
        hwrite = wr;
        haddr  = a;
        hwdata = d;
    endtask

    logic [31:0] dec_addr [4];
    logic [2:0]  dec_sel  [4];

    initial begin
        hreset = 1'b1; hready_in = 1'b1; hr_readyout = 1'b1; prdata = '0;
        drive(2'b00, 3'b010, 1'b0, 32'h0, 32'h0);
        step(2);
        hreset = 1'b0;
        prdata = 32'hDEAD_BEEF;
        expect_sig(S_HADDR1, 32'h0, "rst_haddr1");
        expect_sig(S_HADDR2, 32'h0, "rst_haddr2");
        expect_sig(S_HWDATA1, 32'h0, "rst_hwdata1");
        expect_sig(S_HWDATA2, 32'h0, "rst_hwdata2");
        expect_sig(S_HWR, 32'h0, "rst_hwrite_reg");
        expect_sig(S_HWR1, 32'h0, "rst_hwrite_reg1");
        expect_sig(S_HRESP, 32'h0, "rst_hresp");
        expect_sig(S_HRDY, 32'h1, "rst_hreadyout");
        expect_sig(S_ERRCNT, 32'h0, "rst_err_count");
        expect_sig(S_HRDATA, 32'hDEAD_BEEF, "hrdata_pass");
        step();

        // mapped slots, one per cycle
        dec_addr[0] = 32'h8000_0010; dec_sel[0] = 3'b001;
        dec_addr[1] = 32'h8400_0000; dec_sel[1] = 3'b010;
        dec_addr[2] = 32'h8BFF_FFFC; dec_sel[2] = 3'b100;
        dec_addr[3] = 32'h8800_0000; dec_sel[3] = 3'b100;
        for (int i = 0; i < 4; i++) begin
            drive(2'b10, 3'b010, 1'b0, dec_addr[i], 32'h0);
            expect_sig(S_VALID, 32'h1, "dec_valid");
            expect_sig(S_SEL, {29'd0, dec_sel[i]}, "dec_sel");
            step();
        end
        // unmapped addresses with the controller busy, so no ERROR is raised
        hr_readyout = 1'b0;
        drive(2'b10, 3'b010, 1'b0, 32'h7FFF_FFFC, 32'h0);
        expect_sig(S_VALID, 32'h0, "below_valid");
        expect_sig(S_SEL, 32'h0, "below_sel");
        expect_sig(S_HRDY, 32'h0, "ready_pass_low");
        step();
        drive(2'b10, 3'b010, 1'b0, 32'h8C00_0000, 32'h0);
        expect_sig(S_VALID, 32'h0, "slot3_valid");
        expect_sig(S_SEL, 32'h0, "slot3_sel");
        step();
        hr_readyout = 1'b1;
        drive(2'b00, 3'b010, 1'b0, 32'h0, 32'h0);
        expect_sig(S_HRESP, 32'h0, "no_err_when_busy");
        step();

        drive(2'b10, 3'b010, 1'b1, 32'h8000_0000, 32'h11);
        step();
        drive(2'b10, 3'b010, 1'b1, 32'h8000_0004, 32'h22);
        step();
        for (int k = 0; k < 4; k++) begin
            expect_sig(S_HADDR1, 32'h8000_0004, "pipe_haddr1");
            expect_sig(S_HADDR2, 32'h8000_0000, "pipe_haddr2");
            expect_sig(S_HWDATA1, 32'h22, "pipe_hwdata1");
            expect_sig(S_HWDATA2, 32'h11, "pipe_hwdata2");
            expect_sig(S_HWR, 32'h1, "pipe_hwrite_reg");
            expect_sig(S_HWR1, 32'h1, "pipe_hwrite_reg1");
            hready_in = 1'b0;
            drive(2'b10, 3'b010, 1'b0, 32'h1234_5678, 32'h99);
            if (k < 3) step();
        end
        hready_in = 1'b1;
        drive(2'b00, 3'b010, 1'b0, 32'h0, 32'h0);
        step();

        drive(2'b10, 3'b010, 1'b0, 32'h9000_0000, 32'h0);
        expect_sig(S_VALID, 32'h0, "err_ph_valid");
        expect_sig(S_HRESP, 32'h0, "err_ph_hresp");
        step();
        drive(2'b10, 3'b010, 1'b0, 32'h8000_0000, 32'h0);
        expect_sig(S_HRDY, 32'h0, "err1_hreadyout");
        expect_sig(S_HRESP, 32'h1, "err1_hresp");
        expect_sig(S_VALID, 32'h0, "err1_drop_valid");
        expect_sig(S_ERRCNT, 32'h1, "err1_count");
        step();
        drive(2'b00, 3'b010, 1'b0, 32'h0, 32'h0);
        expect_sig(S_HRDY, 32'h1, "err2_hreadyout");
        expect_sig(S_HRESP, 32'h1, "err2_hresp");
        step();
        expect_sig(S_HRESP, 32'h0, "err_done_hresp");
        expect_sig(S_HRDY, 32'h1, "err_done_hreadyout");

        drive(2'b10, 3'b011, 1'b1, 32'h8000_0000, 32'h0);
        expect_sig(S_VALID, 32'h0, "size_valid");
        expect_sig(S_SEL, 32'h1, "size_sel");
        step();
        drive(2'b00, 3'b010, 1'b0, 32'h0, 32'h0);
        expect_sig(S_HRDY, 32'h0, "size_err1_hreadyout");
        expect_sig(S_HRESP, 32'h1, "size_err1_hresp");
        expect_sig(S_ERRCNT, 32'h2, "size_err_count");
        step();
        expect_sig(S_HRDY, 32'h1, "size_err2_hreadyout");
        expect_sig(S_HRESP, 32'h1, "size_err2_hresp");
        step();
        drive(2'b01, 3'b011, 1'b1, 32'h8000_0000, 32'h0);
        expect_sig(S_VALID, 32'h0, "busy_valid");
        expect_sig(S_HRESP, 32'h0, "busy_ph_hresp");
        step();
        drive(2'b00, 3'b010, 1'b0, 32'h0, 32'h0);
        expect_sig(S_HRESP, 32'h0, "busy_no_err");
        expect_sig(S_ERRCNT, 32'h2, "busy_count");
        step();

        for (int i = 3; i <= 258; i++) begin
            drive(2'b10, 3'b010, 1'b0, 32'h9000_0000, 32'h0);
            step();
            drive(2'b00, 3'b010, 1'b0, 32'h0, 32'h0);
            expect_sig(S_ERRCNT, (i > 255) ? 32'hFF : i, "sat_count");
            step(2);
        end
        drive(2'b10, 3'b010, 1'b0, 32'h9000_0000, 32'h0);
        step();
        drive(2'b00, 3'b010, 1'b0, 32'h0, 32'h0);
        hreset = 1'b1;
        expect_sig(S_HRESP, 32'h1, "pre_rst_hresp");
        expect_sig(S_ERRCNT, 32'hFF, "pre_rst_count");
        step();
        hreset = 1'b0;
        expect_sig(S_HRESP, 32'h0, "mid_rst_hresp");
        expect_sig(S_HRDY, 32'h1, "mid_rst_hreadyout");
        expect_sig(S_ERRCNT, 32'h0, "mid_rst_count");
        expect_sig(S_HADDR1, 32'h0, "mid_rst_haddr1");
        step();
        expect_sig(S_HRESP, 32'h0, "post_rst_hresp");

        for (int t = 0; t < 5 && q.size() > 0; t++) step();
        if (q.size() > 0) begin
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", q.size());
            n_fail += q.size();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
